// File: rtl/membus_decoder.sv
// Memory bus address decoder. It routes one CPU request at a time to the
// lowest-indexed slave channel whose masked base matches the address. An
// unmapped access, or a slave that stays silent for too long, gets an error
// response.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   mem_valid/addr/wdata/
//   mem_wstrb                CPU request
//   mem_ready/rdata, bus_err CPU response; mem_ready pulses for one cycle
//   s_valid[NSLV]            per-slave request strobe (one-hot while active)
//   s_addr/wdata/wstrb       shared slave request payload (latched)
//   s_ready[NSLV], s_rdata   per-slave response, channel i at [32i+31:32i]
//   err_count                saturating count of error responses
module membus_decoder #(
  parameter int unsigned        NSLV      = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE  = {32'h0300_0000, 32'h0200_0008,
                                             32'h0200_0004, 32'h0000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK  = {32'hFF00_0000, 32'hFFFF_FFFF,
                                             32'hFFFF_FFFF, 32'hFFF8_0000},
  parameter int unsigned        TIMEOUT   = 255,
  parameter logic [31:0]        ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              bus_err,
  output logic [NSLV-1:0]   s_valid,
  output logic [31:0]       s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [NSLV-1:0]   s_ready,
  input  logic [NSLV*32-1:0] s_rdata,
  output logic [7:0]        err_count
);

  localparam int unsigned IdxW        = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StActive, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   sel_q, sel_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              hit;
  logic [IdxW-1:0]   hit_idx;
  logic              sel_ready;
  logic [31:0]       sel_rdata;

  // Scan from the top down so the lowest matching channel is assigned last.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((mem_addr & SLV_MASK[i*32 +: 32]) == (SLV_BASE[i*32 +: 32] & SLV_MASK[i*32 +: 32])) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  assign sel_ready = s_ready[sel_q];
  assign sel_rdata = s_rdata[32*int'(sel_q) +: 32];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          if (hit) begin
            sel_d   = hit_idx;
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            wstrb_d = mem_wstrb;
            cnt_d   = '0;
            state_d = StActive;
          end else begin
            // Unmapped: nothing is latched, so writes leave no trace.
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = StResp;
          end
        end
      end
      StActive: begin
        // A ready arriving on the timeout cycle still wins.
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if ((TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
        if (err_q && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Masking with reset keeps a reset raised during RESP from completing the access.
  assign mem_ready = (state_q == StResp) && !reset;
  assign mem_rdata = rdata_q;
  assign bus_err   = err_q;
  assign s_valid   = (state_q == StActive) ? (NSLV'(1) << sel_q) : '0;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign err_count = err_cnt_q;

endmodule
